// File: rtl/iobuf_bank_reg.sv
// iobuf_bank_reg: registered bidirectional I/O bank with a direction
// turnaround state machine, a multi-stage input capture pipeline and a
// data-valid flag. WIDTH pads share one direction control. The global
// tri-state hook (gts) releases the pads asynchronously without touching
// any state.
module iobuf_bank_reg #(
  parameter int WIDTH = 8,
  parameter int TURN  = 1,
  parameter int SYNC  = 2
) (
  input  logic             C,
  input  logic             RN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  inout  wire  [WIDTH-1:0] IO,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  output logic             DIR,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } state_t;

  // Turnaround counter reload value and the zero-turnaround shortcut.
  localparam logic [3:0] TURN_LOAD = 4'(TURN) - 4'd1;
  localparam logic       TURN_ZERO = (TURN == 0);
  // Fill count at which the capture pipeline holds only receive-mode data.
  localparam logic [1:0] SYNC_FULL = 2'(SYNC);

  // Global tri-state hook. Simulation environments tie or force this net to
  // glbl.GTS; when 1 it releases IO without affecting the FSM or flags.
  logic gts;
  assign gts = 1'b0;

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_s;
  logic [WIDTH-1:0] data_r;
  logic             drive_r;
  logic             dir_r;
  logic             busy_r;
  logic [1:0]       fill_r;
  logic [1:0]       fill_s;
  logic             valid_r;
  logic [WIDTH-1:0] sync_r [SYNC];

  // Next-state and turnaround counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_RX: begin
        if (!T) begin
          if (TURN_ZERO) begin
            state_s = ST_TX;
            cnt_s   = 4'd0;
          end else begin
            state_s = ST_TURN_TX;
            cnt_s   = TURN_LOAD;
          end
        end else begin
          state_s = ST_RX;
          cnt_s   = 4'd0;
        end
      end
      ST_TURN_TX: begin
        // A receive request aborts the turnaround before anything is driven.
        if (T) begin
          state_s = ST_RX;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_s = ST_TX;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_TURN_TX;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_TX: begin
        if (T) begin
          if (TURN_ZERO) begin
            state_s = ST_RX;
            cnt_s   = 4'd0;
          end else begin
            state_s = ST_TURN_RX;
            cnt_s   = TURN_LOAD;
          end
        end else begin
          state_s = ST_TX;
          cnt_s   = 4'd0;
        end
      end
      ST_TURN_RX: begin
        // Release always runs the full turnaround; T is ignored here.
        if (cnt_r == 4'd0) begin
          state_s = ST_RX;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_TURN_RX;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_RX;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Receive fill counter: restarts on every entry into RX and saturates.
  always_comb begin
    fill_s = fill_r;
    if (state_s != ST_RX) begin
      fill_s = 2'd0;
    end else if (state_r != ST_RX) begin
      fill_s = 2'd0;
    end else if (fill_r != SYNC_FULL) begin
      fill_s = fill_r + 2'd1;
    end else begin
      fill_s = fill_r;
    end
  end

  // State register and turnaround counter.
  always_ff @(posedge C) begin
    if (!RN) begin
      state_r <= ST_RX;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output data register, loaded whenever CE is high regardless of state.
  always_ff @(posedge C) begin
    if (!RN) begin
      data_r <= '0;
    end else if (CE) begin
      data_r <= I;
    end else begin
      data_r <= data_r;
    end
  end

  // Registered drive enable and status flags, decoded from the next state
  // so they line up exactly with the state register.
  always_ff @(posedge C) begin
    if (!RN) begin
      drive_r <= 1'b0;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      drive_r <= (state_s == ST_TX);
      dir_r   <= (state_s == ST_TX);
      busy_r  <= (state_s == ST_TURN_TX) || (state_s == ST_TURN_RX);
    end
  end

  // Input capture pipeline: pad value sampled every cycle, in every state.
  always_ff @(posedge C) begin
    if (!RN) begin
      for (int s = 0; s < SYNC; s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= IO;
      for (int s = 1; s < SYNC; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Fill counter and VALID flag: VALID rises once the whole pipeline has
  // been refilled with pad data captured in RX.
  always_ff @(posedge C) begin
    if (!RN) begin
      fill_r  <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      fill_r  <= fill_s;
      valid_r <= (state_s == ST_RX) && (fill_s == SYNC_FULL);
    end
  end

  assign IO    = (drive_r && !gts) ? data_r : {WIDTH{1'bz}};
  assign O     = sync_r[SYNC-1];
  assign VALID = valid_r;
  assign DIR   = dir_r;
  assign BUSY  = busy_r;

endmodule

// File: tb/tb_iobuf_bank_reg.sv
// Directed bench for iobuf_bank_reg: one bank with TURN=2 and one with
// TURN=3 (abort behaviour), both SYNC=2, WIDTH=8. External pad drivers are
// enabled only while the bank is expected to be released, so a released pad
// reads back the external pattern.
module tb_iobuf_bank_reg;

  logic       c;
  logic       rn;
  logic       ce;
  logic [7:0] i_d;
  logic       t;
  logic       t3;
  logic       ext_en;
  logic [7:0] ext_val;
  logic [7:0] ext3_val;
  wire  [7:0] io;
  wire  [7:0] io3;
  logic [7:0] o;
  logic [7:0] o3;
  logic       valid;
  logic       valid3;
  logic       dir;
  logic       dir3;
  logic       busy;
  logic       busy3;

  int vectors;
  int miscompares;

  assign io  = ext_en ? ext_val : {8{1'bz}};
  assign io3 = ext3_val;

  iobuf_bank_reg #(.WIDTH(8), .TURN(2), .SYNC(2)) dut (
    .C(c), .RN(rn), .CE(ce), .I(i_d), .T(t), .IO(io),
    .O(o), .VALID(valid), .DIR(dir), .BUSY(busy)
  );

  iobuf_bank_reg #(.WIDTH(8), .TURN(3), .SYNC(2)) dut3 (
    .C(c), .RN(rn), .CE(ce), .I(i_d), .T(t3), .IO(io3),
    .O(o3), .VALID(valid3), .DIR(dir3), .BUSY(busy3)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rn       = 1'b0;
    ce       = 1'b1;
    i_d      = 8'h00;
    t        = 1'b1;
    t3       = 1'b1;
    ext_en   = 1'b1;
    ext_val  = 8'hA5;
    ext3_val = 8'h69;

    // Reset for two edges with the pads held at A5.
    tick();
    tick();
    chk("rst_o", o, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_io_hiz", io, 8'hA5);
    rn = 1'b1;
    tick();
    chk("fill1_valid", valid, 1'b0);
    tick();
    chk("fill2_valid", valid, 1'b1);
    chk("fill2_o", o, 8'hA5);

    // Drive entry with TURN=2.
    t      = 1'b0;
    i_d    = 8'h3C;
    ext_en = 1'b0;
    tick();
    chk("turn_k_busy", busy, 1'b1);
    chk("turn_k_dir", dir, 1'b0);
    chk("turn_k_valid", valid, 1'b0);
    tick();
    chk("turn_k1_busy", busy, 1'b1);
    chk("turn_k1_dir", dir, 1'b0);
    tick();
    chk("tx_dir", dir, 1'b1);
    chk("tx_busy", busy, 1'b0);
    chk("tx_io", io, 8'h3C);

    // CE hold while in TX.
    i_d = 8'h11;
    tick();
    chk("ce_load_io", io, 8'h11);
    ce  = 1'b0;
    i_d = 8'h22;
    tick();
    chk("ce_hold_io_a", io, 8'h11);
    tick();
    chk("ce_hold_io_b", io, 8'h11);
    ce = 1'b1;
    tick();
    chk("ce_reload_io", io, 8'h22);

    // Global tri-state while driving FF.
    i_d = 8'hFF;
    tick();
    chk("gts_pre_io", io, 8'hFF);
    force dut.gts = 1'b1;
    ext_en  = 1'b1;
    ext_val = 8'h0F;
    #1;
    chk("gts_io_hiz", io, 8'h0F);
    chk("gts_dir", dir, 1'b1);
    tick();
    chk("gts_edge_dir", dir, 1'b1);
    chk("gts_edge_busy", busy, 1'b0);
    chk("gts_edge_io", io, 8'h0F);
    ext_en = 1'b0;
    release dut.gts;
    #1;
    chk("gts_off_io", io, 8'hFF);
    tick();
    chk("gts_off_dir", dir, 1'b1);
    chk("gts_off_io2", io, 8'hFF);

    // Release from TX: T=1 sampled at edge m.
    t = 1'b1;
    tick();
    ext_en  = 1'b1;
    ext_val = 8'h5A;
    #1;
    chk("rel_m_io_hiz", io, 8'h5A);
    chk("rel_m_dir", dir, 1'b0);
    chk("rel_m_busy", busy, 1'b1);
    t = 1'b0;
    tick();
    chk("rel_m1_busy", busy, 1'b1);
    chk("rel_m1_valid", valid, 1'b0);
    t = 1'b1;
    tick();
    chk("rel_m2_busy", busy, 1'b0);
    chk("rel_m2_dir", dir, 1'b0);
    chk("rel_m2_valid", valid, 1'b0);
    tick();
    chk("rel_m3_valid", valid, 1'b0);
    tick();
    chk("rel_m4_valid", valid, 1'b1);
    chk("rel_m4_o", o, 8'h5A);

    // Abort on the TURN=3 bank: one cycle of T=0, then T=1.
    t3 = 1'b0;
    tick();
    chk("abort_k_busy", busy3, 1'b1);
    chk("abort_k_dir", dir3, 1'b0);
    chk("abort_k_valid", valid3, 1'b0);
    t3 = 1'b1;
    tick();
    chk("abort_k1_busy", busy3, 1'b0);
    chk("abort_k1_dir", dir3, 1'b0);
    chk("abort_k1_io", io3, 8'h69);
    tick();
    chk("abort_k2_valid", valid3, 1'b0);
    tick();
    chk("abort_k3_valid", valid3, 1'b1);
    chk("abort_k3_o", o3, 8'h69);

    // T toggling every cycle never reaches TX on the TURN=3 bank.
    for (int n = 0; n < 6; n++) begin
      t3 = ~t3;
      tick();
      chk("toggle_dir", dir3, 1'b0);
      chk("toggle_io", io3, 8'h69);
    end
    t3 = 1'b1;

    // Reset while driving releases the pads with no turnaround.
    t      = 1'b0;
    i_d    = 8'h77;
    ext_en = 1'b0;
    tick();
    tick();
    tick();
    chk("rtx_io", io, 8'h77);
    chk("rtx_dir", dir, 1'b1);
    rn = 1'b0;
    tick();
    ext_en  = 1'b1;
    ext_val = 8'h33;
    #1;
    chk("rtx_rst_dir", dir, 1'b0);
    chk("rtx_rst_busy", busy, 1'b0);
    chk("rtx_rst_valid", valid, 1'b0);
    chk("rtx_rst_o", o, 8'h00);
    chk("rtx_rst_io_hiz", io, 8'h33);
    rn = 1'b1;
    t  = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
